muldiv_ctrl: RTL and testbench

//  Sequences HI/LO-producing ops (MULT/MULTU/DIV/DIVU/MTHI/MTLO) in EX: runs multi-cycle multiply and an

---
 rtl/muldiv_pkg.sv | 33 +++
 rtl/muldiv_div_iter.sv | 46 ++++
 rtl/muldiv_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_muldiv_ctrl.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared definitions for the HI/LO sequencer.
//   - op encodings carried on ex_op
//   - FSM state encoding used by muldiv_ctrl
//   - divider iteration count (fixed at the 32-bit operand width)
//   - small helpers for magnitude and sign restoration of divide operands/results
package muldiv_pkg;

   localparam logic [2:0] OP_MULT  = 3'd0;
   localparam logic [2:0] OP_MULTU = 3'd1;
   localparam logic [2:0] OP_DIV   = 3'd2;
   localparam logic [2:0] OP_DIVU  = 3'd3;
   localparam logic [2:0] OP_MTHI  = 3'd4;
   localparam logic [2:0] OP_MTLO  = 3'd5;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_MUL  = 2'd1;
   localparam logic [1:0] ST_DIV  = 2'd2;
   localparam logic [1:0] ST_DONE = 2'd3;

   localparam int DIV_CYCLES = 32;

   // Absolute value when the op is signed; raw value otherwise.
   // 0x8000_0000 maps to itself, which is the correct unsigned magnitude.
   function automatic logic [31:0] mag32(input logic [31:0] v, input logic is_signed);
      return (is_signed && v[31]) ? (~v + 32'd1) : v;
   endfunction

   // Two's-complement negate when neg is set.
   function automatic logic [31:0] neg_if(input logic [31:0] v, input logic neg);
      return neg ? (~v + 32'd1) : v;
   endfunction

endpackage

// File: rtl/muldiv_div_iter.sv
// div_iter: 32-bit unsigned restoring divider, one quotient bit per step.
//   clk    in   clock
//   start  in   load dividend a / divisor b, clear partial remainder
//   a      in   dividend (magnitude)
//   b      in   divisor (magnitude)
//   step   in   perform one restoring iteration this cycle
//   q      out  quotient bits after the current step (combinational look-ahead)
//   r      out  partial remainder after the current step (combinational look-ahead)
// q/r show the result of the step being taken this cycle, so after the
// 32nd step the owner can capture the final quotient/remainder on the
// same edge that the step registers.
module div_iter
(
   input  logic        clk,
   input  logic        start,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        step,
   output logic [31:0] q,
   output logic [31:0] r
);

   logic [31:0] quo;
   logic [31:0] rem;
   logic [31:0] dvs;
   logic [32:0] shifted;
   logic        ge;

   // Bring the next dividend bit into the remainder; subtract if it fits.
   assign shifted = {rem, quo[31]};
   assign ge      = shifted >= {1'b0, dvs};
   assign q       = {quo[30:0], ge};
   assign r       = ge ? 32'(shifted - {1'b0, dvs}) : shifted[31:0];

   always_ff @(posedge clk) begin
      if (start) begin
         quo <= a;
         rem <= '0;
         dvs <= b;
      end else if (step) begin
         quo <= q;
         rem <= r;
      end
   end

endmodule

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: sequences HI/LO-producing ops sitting in EX.
//   clk            in   clock
//   resetn         in   async active-low reset
//   ex_op_valid    in   HI/LO op present in EX
//   ex_op          in   op code (muldiv_pkg OP_*)
//   src_a, src_b   in   rs / rt values
//   ex_hold        in   EX held by other causes
//   flush          in   exception/eret flush, kills the EX op
//   div_mul_stall  out  hold ID/EX while a multiply/divide is in flight
//   hi, lo         out  architectural HI/LO
//   busy           out  FSM not idle
// MUL_CYCLES sets the multiplier register depth (1..15).
module muldiv_ctrl
   import muldiv_pkg::*;
#(
   parameter int MUL_CYCLES = 2
)
(
   input  logic        clk,
   input  logic        resetn,
   input  logic        ex_op_valid,
   input  logic [2:0]  ex_op,
   input  logic [31:0] src_a,
   input  logic [31:0] src_b,
   input  logic        ex_hold,
   input  logic        flush,
   output logic        div_mul_stall,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic        busy
);

   logic [1:0]  state;
   logic [4:0]  cnt;
   logic [31:0] res_hi;
   logic [31:0] res_lo;
   logic        is_mul_op;
   logic        is_div_op;
   logic        op_signed;
   logic        accept;

   assign is_mul_op = (ex_op == OP_MULT) || (ex_op == OP_MULTU);
   assign is_div_op = (ex_op == OP_DIV)  || (ex_op == OP_DIVU);
   assign op_signed = (ex_op == OP_MULT) || (ex_op == OP_DIV);
   assign accept    = (state == ST_IDLE) && ex_op_valid && (is_mul_op || is_div_op) && !flush;
   assign busy      = (state != ST_IDLE);

   // Stall never looks at ex_hold: DONE releases the pipeline even while held.
   always_comb begin
      div_mul_stall = 1'b0;
      if (resetn && !flush) begin
         case (state)
            ST_IDLE: div_mul_stall = accept;
            ST_MUL,
            ST_DIV:  div_mul_stall = ex_op_valid;
            default: div_mul_stall = 1'b0;
         endcase
      end
   end

   // ---- multiplier stage p0: extend operands to 64 bits (sign or zero) ----
   logic signed [63:0] mul_a_p0;
   logic signed [63:0] mul_b_p0;
   logic signed [63:0] prod_p [MUL_CYCLES];
   logic [MUL_CYCLES-1:0] vld_p;

   assign mul_a_p0 = {{32{op_signed & src_a[31]}}, src_a};
   assign mul_b_p0 = {{32{op_signed & src_b[31]}}, src_b};

   // ---- multiplier stages p1..pN: product captured at accept, then shifted ----
   always_ff @(posedge clk) begin
      if (accept && is_mul_op)
         prod_p[0] <= mul_a_p0 * mul_b_p0;
      for (int i = 1; i < MUL_CYCLES; i++)
         prod_p[i] <= prod_p[i-1];
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         vld_p <= '0;
      end else begin
         vld_p[0] <= accept && is_mul_op;
         for (int i = 1; i < MUL_CYCLES; i++)
            vld_p[i] <= vld_p[i-1];
      end
   end

   // ---- divider: magnitudes in, sign restored on the way out ----
   logic [31:0] div_q;
   logic [31:0] div_r;
   logic [31:0] a_mag_l;
   logic        q_neg_l;
   logic        r_neg_l;
   logic        div_zero_l;
   logic [31:0] q_fix;
   logic [31:0] r_fix;

   div_iter u_div_iter (
      .clk   (clk),
      .start (accept && is_div_op),
      .a     (mag32(src_a, op_signed)),
      .b     (mag32(src_b, op_signed)),
      .step  (state == ST_DIV),
      .q     (div_q),
      .r     (div_r)
   );

   always_ff @(posedge clk) begin
      if (accept && is_div_op) begin
         a_mag_l    <= mag32(src_a, op_signed);
         q_neg_l    <= op_signed && (src_a[31] ^ src_b[31]);
         r_neg_l    <= op_signed && src_a[31];
         div_zero_l <= (src_b == 32'd0);
      end
   end

   // Divide-by-zero: all-ones quotient magnitude and |a| remainder before sign fix.
   assign q_fix = neg_if(div_zero_l ? 32'hFFFF_FFFF : div_q, q_neg_l);
   assign r_fix = neg_if(div_zero_l ? a_mag_l : div_r, r_neg_l);

   // ---- control FSM and architectural HI/LO ----
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state  <= ST_IDLE;
         cnt    <= '0;
         hi     <= '0;
         lo     <= '0;
         res_hi <= '0;
         res_lo <= '0;
      end else if (flush) begin
         state <= ST_IDLE;
         cnt   <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  if (is_mul_op) begin
                     state <= ST_MUL;
                     cnt   <= 5'(MUL_CYCLES - 1);
                  end else begin
                     state <= ST_DIV;
                     cnt   <= 5'(DIV_CYCLES - 1);
                  end
               end else if (ex_op_valid && !ex_hold) begin
                  if (ex_op == OP_MTHI)
                     hi <= src_a;
                  else if (ex_op == OP_MTLO)
                     lo <= src_a;
               end
            end
            ST_MUL: begin
               if (!ex_op_valid) begin
                  state <= ST_IDLE;
                  cnt   <= '0;
               end else if (cnt == 5'd0 && vld_p[MUL_CYCLES-1]) begin
                  res_hi <= prod_p[MUL_CYCLES-1][63:32];
                  res_lo <= prod_p[MUL_CYCLES-1][31:0];
                  state  <= ST_DONE;
               end else if (cnt != 5'd0) begin
                  cnt <= cnt - 5'd1;
               end
            end
            ST_DIV: begin
               if (!ex_op_valid) begin
                  state <= ST_IDLE;
                  cnt   <= '0;
               end else if (cnt == 5'd0) begin
                  res_hi <= r_fix;
                  res_lo <= q_fix;
                  state  <= ST_DONE;
               end else begin
                  cnt <= cnt - 5'd1;
               end
            end
            ST_DONE: begin
               if (!ex_hold) begin
                  hi    <= res_hi;
                  lo    <= res_lo;
                  state <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb_muldiv_ctrl: self-checking bench for muldiv_ctrl.
// Expected HI/LO come from a plain-arithmetic model of MULT/MULTU/DIV/DIVU
// and a bench-side copy of the architectural HI/LO registers.
module tb_muldiv_ctrl;
   import muldiv_pkg::*;

   localparam int MUL_CYCLES = 2;
   localparam int MUL_STALL  = 1 + MUL_CYCLES;
   localparam int DIV_STALL  = 1 + 32;

   logic        clk = 1'b0;
   logic        resetn;
   logic        ex_op_valid;
   logic [2:0]  ex_op;
   logic [31:0] src_a;
   logic [31:0] src_b;
   logic        ex_hold;
   logic        flush;
   logic        div_mul_stall;
   logic [31:0] hi;
   logic [31:0] lo;
   logic        busy;

   int n_cmp = 0;
   int n_bad = 0;
   logic [31:0] exp_hi = '0;
   logic [31:0] exp_lo = '0;

   always #5 clk = ~clk;

   muldiv_ctrl #(.MUL_CYCLES(MUL_CYCLES)) dut (
      .clk           (clk),
      .resetn        (resetn),
      .ex_op_valid   (ex_op_valid),
      .ex_op         (ex_op),
      .src_a         (src_a),
      .src_b         (src_b),
      .ex_hold       (ex_hold),
      .flush         (flush),
      .div_mul_stall (div_mul_stall),
      .hi            (hi),
      .lo            (lo),
      .busy          (busy)
   );

   // {hi, lo} an op should leave behind, from the arithmetic definition.
   function automatic logic [63:0] ref_hilo(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      longint sa, sb, q, r;
      logic [63:0] p;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      case (op)
         OP_MULT:  p = 64'(sa * sb);
         OP_MULTU: p = {32'd0, a} * {32'd0, b};
         OP_DIVU:  p = (b == 32'd0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
         default: begin
            if (sb == 0) begin
               q = (sa < 0) ? -longint'(64'hFFFF_FFFF) : longint'(64'hFFFF_FFFF);
               r = sa;
            end else begin
               q = sa / sb;
               r = sa % sb;
            end
            p = {r[31:0], q[31:0]};
         end
      endcase
      return p;
   endfunction

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs;
      ex_op_valid = 1'b0;
      ex_op       = OP_MTLO;
      ex_hold     = 1'b0;
      flush       = 1'b0;
      src_a       = '0;
      src_b       = '0;
   endtask

   // Present op in EX until the stall drops, then let the commit edge pass.
   task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input bit scramble, output int stall_cyc, output bit to);
      ex_op = op; src_a = a; src_b = b;
      ex_op_valid = 1'b1; ex_hold = 1'b0; flush = 1'b0;
      stall_cyc = 0; to = 1'b0;
      #1;
      while (div_mul_stall === 1'b1) begin
         stall_cyc++;
         if (stall_cyc > 100) begin to = 1'b1; break; end
         tick();
         if (scramble) begin src_a = $urandom; src_b = $urandom; end
      end
      if (!to) tick();
      ex_op_valid = 1'b0;
   endtask

   task automatic test_reset;
      idle_inputs();
      resetn = 1'b0;
      ex_op_valid = 1'b1; ex_op = OP_MULT;
      repeat (2) tick();
      n_cmp++; if (hi !== 32'd0) begin n_bad++; $display("FAIL reset_hi: got %h want 0", hi); end
      n_cmp++; if (lo !== 32'd0) begin n_bad++; $display("FAIL reset_lo: got %h want 0", lo); end
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
      n_cmp++; if (div_mul_stall !== 1'b0) begin n_bad++; $display("FAIL reset_stall: got %b want 0", div_mul_stall); end
      ex_op_valid = 1'b0;
      resetn = 1'b1;
      tick();
      exp_hi = '0; exp_lo = '0;
   endtask

   task automatic test_mult;
      int sc; bit to;
      run_op(OP_MULT, 32'hFFFF_FFFD, 32'd5, 1'b0, sc, to);
      exp_hi = 32'hFFFF_FFFF; exp_lo = 32'hFFFF_FFF1;
      n_cmp++; if (sc !== MUL_STALL) begin n_bad++; $display("FAIL mult_stall_cycles: got %0d want %0d", sc, MUL_STALL); end
      n_cmp++; if (hi !== exp_hi) begin n_bad++; $display("FAIL mult_hi: got %h want %h", hi, exp_hi); end
      n_cmp++; if (lo !== exp_lo) begin n_bad++; $display("FAIL mult_lo: got %h want %h", lo, exp_lo); end
   endtask

   task automatic test_div_vectors;
      logic [2:0]  v_op [4] = '{OP_DIVU, OP_DIV, OP_DIV, OP_DIVU};
      logic [31:0] v_a  [4] = '{32'd100, 32'hFFFF_FFF9, 32'd5, 32'h8000_0000};
      logic [31:0] v_b  [4] = '{32'd7, 32'd2, 32'd0, 32'd1};
      logic [31:0] v_hi [4] = '{32'd2, 32'hFFFF_FFFF, 32'd5, 32'd0};
      logic [31:0] v_lo [4] = '{32'd14, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h8000_0000};
      int sc; bit to;
      for (int i = 0; i < 4; i++) begin
         run_op(v_op[i], v_a[i], v_b[i], 1'b0, sc, to);
         exp_hi = v_hi[i]; exp_lo = v_lo[i];
         n_cmp++; if (sc !== DIV_STALL) begin n_bad++; $display("FAIL div_vec%0d_stall: got %0d want %0d", i, sc, DIV_STALL); end
         n_cmp++; if ({hi, lo} !== {exp_hi, exp_lo}) begin n_bad++; $display("FAIL div_vec%0d_hilo: got %h_%h want %h_%h", i, hi, lo, exp_hi, exp_lo); end
      end
   endtask

   // Random ops issued back to back; operands change while the op runs.
   task automatic test_random_back_to_back;
      int sc; bit to;
      logic [2:0] op; logic [31:0] a, b;
      for (int n = 0; n < 30; n++) begin
         op = 3'($urandom_range(0, 5));
         a  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 100)) : $urandom;
         case ($urandom_range(0, 3))
            0:       b = 32'd0;
            1:       b = 32'($urandom_range(1, 40));
            2:       b = 32'hFFFF_FFFF;
            default: b = $urandom;
         endcase
         if (op == OP_MTHI || op == OP_MTLO) begin
            ex_op = op; src_a = a; src_b = b; ex_op_valid = 1'b1;
            #1;
            n_cmp++; if (div_mul_stall !== 1'b0) begin n_bad++; $display("FAIL rnd%0d_mt_stall: got %b want 0", n, div_mul_stall); end
            tick();
            ex_op_valid = 1'b0;
            if (op == OP_MTHI) exp_hi = a; else exp_lo = a;
         end else begin
            run_op(op, a, b, 1'b1, sc, to);
            {exp_hi, exp_lo} = ref_hilo(op, a, b);
            n_cmp++;
            if (sc !== ((op == OP_DIV || op == OP_DIVU) ? DIV_STALL : MUL_STALL)) begin
               n_bad++; $display("FAIL rnd%0d_stall op=%0d: got %0d cycles", n, op, sc);
            end
         end
         n_cmp++;
         if ({hi, lo} !== {exp_hi, exp_lo}) begin
            n_bad++; $display("FAIL rnd%0d_hilo op=%0d a=%h b=%h: got %h_%h want %h_%h", n, op, a, b, hi, lo, exp_hi, exp_lo);
         end
      end
   endtask

   task automatic test_flush;
      int sc; bit to;
      ex_op = OP_DIVU; src_a = 32'd1000; src_b = 32'd3; ex_op_valid = 1'b1; flush = 1'b1;
      #1;
      n_cmp++; if (div_mul_stall !== 1'b0) begin n_bad++; $display("FAIL flush_accept_stall: got %b want 0", div_mul_stall); end
      tick();
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL flush_accept_busy: got %b want 0", busy); end
      flush = 1'b0;
      #1;
      n_cmp++; if (div_mul_stall !== 1'b1) begin n_bad++; $display("FAIL flush_div_start_stall: got %b want 1", div_mul_stall); end
      tick();
      repeat (9) tick();
      flush = 1'b1;
      #1;
      n_cmp++; if (div_mul_stall !== 1'b0) begin n_bad++; $display("FAIL flush_iter10_stall: got %b want 0", div_mul_stall); end
      tick();
      flush = 1'b0; ex_op_valid = 1'b0;
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL flush_iter10_busy: got %b want 0", busy); end
      n_cmp++; if ({hi, lo} !== {exp_hi, exp_lo}) begin n_bad++; $display("FAIL flush_hilo_kept: got %h_%h want %h_%h", hi, lo, exp_hi, exp_lo); end
      run_op(OP_MULTU, 32'd6, 32'd7, 1'b0, sc, to);
      exp_hi = 32'd0; exp_lo = 32'd42;
      n_cmp++; if ({hi, lo} !== {exp_hi, exp_lo}) begin n_bad++; $display("FAIL flush_next_multu: got %h_%h want %h_%h", hi, lo, exp_hi, exp_lo); end
   endtask

   task automatic test_hold_done;
      int g;
      logic [31:0] a = 32'h1234_5678;
      logic [31:0] b = 32'h0009_ABCD;
      ex_op = OP_MULTU; src_a = a; src_b = b; ex_op_valid = 1'b1;
      #1;
      g = 0;
      while (div_mul_stall === 1'b1 && g < 100) begin tick(); g++; end
      n_cmp++; if (g !== MUL_STALL) begin n_bad++; $display("FAIL hold_stall_cycles: got %0d want %0d", g, MUL_STALL); end
      ex_hold = 1'b1;
      for (int k = 0; k < 3; k++) begin
         #1;
         n_cmp++;
         if (div_mul_stall !== 1'b0 || busy !== 1'b1 || {hi, lo} !== {exp_hi, exp_lo}) begin
            n_bad++; $display("FAIL hold_cycle%0d: stall=%b busy=%b hilo=%h_%h want stall=0 busy=1 hilo=%h_%h", k, div_mul_stall, busy, hi, lo, exp_hi, exp_lo);
         end
         tick();
      end
      ex_hold = 1'b0;
      tick();
      ex_op_valid = 1'b0;
      {exp_hi, exp_lo} = ref_hilo(OP_MULTU, a, b);
      n_cmp++; if ({hi, lo} !== {exp_hi, exp_lo}) begin n_bad++; $display("FAIL hold_release_commit: got %h_%h want %h_%h", hi, lo, exp_hi, exp_lo); end
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL hold_release_idle: got busy=%b want 0", busy); end
      // second op: hold, then flush on the release cycle
      ex_op = OP_MULTU; src_a = 32'd77; src_b = 32'd99; ex_op_valid = 1'b1;
      #1;
      g = 0;
      while (div_mul_stall === 1'b1 && g < 100) begin tick(); g++; end
      ex_hold = 1'b1;
      repeat (2) tick();
      ex_hold = 1'b0; flush = 1'b1;
      tick();
      flush = 1'b0; ex_op_valid = 1'b0;
      n_cmp++; if ({hi, lo} !== {exp_hi, exp_lo}) begin n_bad++; $display("FAIL hold_flush_no_commit: got %h_%h want %h_%h", hi, lo, exp_hi, exp_lo); end
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL hold_flush_idle: got busy=%b want 0", busy); end
   endtask

   task automatic test_abort;
      ex_op = OP_MULT; src_a = 32'd1234; src_b = 32'd4321; ex_op_valid = 1'b1;
      tick();
      ex_op_valid = 1'b0;
      #1;
      n_cmp++; if (div_mul_stall !== 1'b0) begin n_bad++; $display("FAIL abort_stall: got %b want 0", div_mul_stall); end
      tick();
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL abort_busy: got %b want 0", busy); end
      repeat (3) tick();
      n_cmp++; if ({hi, lo} !== {exp_hi, exp_lo}) begin n_bad++; $display("FAIL abort_hilo: got %h_%h want %h_%h", hi, lo, exp_hi, exp_lo); end
   endtask

   task automatic test_reset_mid_div_and_mthi;
      ex_op = OP_DIV; src_a = 32'hFFFF_0000; src_b = 32'd9; ex_op_valid = 1'b1;
      repeat (6) tick();
      #1 resetn = 1'b0;
      #1;
      exp_hi = '0; exp_lo = '0;
      n_cmp++;
      if (busy !== 1'b0 || div_mul_stall !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
         n_bad++; $display("FAIL reset_mid_div: busy=%b stall=%b hi=%h lo=%h want all 0", busy, div_mul_stall, hi, lo);
      end
      tick();
      ex_op_valid = 1'b0;
      resetn = 1'b1;
      tick();
      ex_op = OP_MTHI; src_a = 32'h0000_1234; ex_op_valid = 1'b1; ex_hold = 1'b1;
      tick();
      n_cmp++; if (hi !== 32'd0) begin n_bad++; $display("FAIL mthi_held: got %h want 0", hi); end
      ex_hold = 1'b0;
      tick();
      exp_hi = 32'h0000_1234;
      n_cmp++; if (hi !== exp_hi) begin n_bad++; $display("FAIL mthi_write: got %h want %h", hi, exp_hi); end
      ex_op_valid = 1'b0; src_a = 32'h5555_5555;
      tick();
      n_cmp++; if ({hi, lo} !== {exp_hi, exp_lo}) begin n_bad++; $display("FAIL mthi_once: got %h_%h want %h_%h", hi, lo, exp_hi, exp_lo); end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_mult();
      test_div_vectors();
      test_flush();
      test_hold_done();
      test_abort();
      test_random_back_to_back();
      test_reset_mid_div_and_mthi();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
